// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one backing-memory line port between the icache (I)
// and dcache (D) controllers. Each port has a one-entry request buffer. One line
// transaction is granted at a time, by round-robin or fixed D priority. Ready and
// data are routed back to the owning port. Grant and conflict counters are kept.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 128,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req_valid_i,
    input  logic              i_req_rw_i,
    input  logic [ADDR_W-1:0] i_req_addr_i,
    input  logic [LINE_W-1:0] i_req_data_i,
    output logic              i_res_ready_o,
    output logic [LINE_W-1:0] i_res_data_o,
    input  logic              d_req_valid_i,
    input  logic              d_req_rw_i,
    input  logic [ADDR_W-1:0] d_req_addr_i,
    input  logic [LINE_W-1:0] d_req_data_i,
    output logic              d_res_ready_o,
    output logic [LINE_W-1:0] d_res_data_o,
    output logic              mem_valid_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic [31:0]       gnt_i_cnt_o,
    output logic [31:0]       gnt_d_cnt_o,
    output logic [31:0]       conflict_cnt_o
);

    localparam int unsigned CNT_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_last_q;
    logic              conflict;

    logic              i_pend_q, i_rw_q;
    logic [ADDR_W-1:0] i_addr_q;
    logic [LINE_W-1:0] i_data_q;
    logic              d_pend_q, d_rw_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [LINE_W-1:0] d_data_q;

    logic              busy, done, i_cap, d_cap;
    logic [CNT_W-1:0]  gnt_i_q, gnt_d_q, conflict_q;

    // Memory side is driven straight from the owner slot while busy, zero otherwise
    assign busy        = (state_q == ST_BUSY);
    assign done        = busy & mem_ready_i;
    assign mem_valid_o = busy;
    assign mem_rw_o    = busy & ((owner_q == PORT_D) ? d_rw_q : i_rw_q);
    assign mem_addr_o  = busy ? ((owner_q == PORT_D) ? d_addr_q : i_addr_q) : '0;
    assign mem_wdata_o = busy ? ((owner_q == PORT_D) ? d_data_q : i_data_q) : '0;

    // Response routing: ready only to the owner, data broadcast
    assign i_res_ready_o = done & (owner_q == PORT_I);
    assign d_res_ready_o = done & (owner_q == PORT_D);
    assign i_res_data_o  = mem_rdata_i;
    assign d_res_data_o  = mem_rdata_i;

    assign i_cap = i_req_valid_i & ~i_pend_q & ~i_res_ready_o;
    assign d_cap = d_req_valid_i & ~d_pend_q & ~d_res_ready_o;

    assign gnt_i_cnt_o    = gnt_i_q;
    assign gnt_d_cnt_o    = gnt_d_q;
    assign conflict_cnt_o = conflict_q;

    // Next-state and owner selection
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        conflict = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    if (i_pend_q && d_pend_q) begin
                        conflict = 1'b1;
                        owner_d  = (FIXED_PRIO != 0) ? PORT_D : ~rr_last_q;
                    end else begin
                        owner_d  = d_pend_q ? PORT_D : PORT_I;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner and round-robin history
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_I;
            rr_last_q <= PORT_D;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (done) rr_last_q <= owner_q;
        end
    end

    // Port I request buffer: capture when empty, release on its response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            i_pend_q <= 1'b0;
            i_rw_q   <= 1'b0;
            i_addr_q <= '0;
            i_data_q <= '0;
        end else if (i_cap) begin
            i_pend_q <= 1'b1;
            i_rw_q   <= i_req_rw_i;
            i_addr_q <= i_req_addr_i;
            i_data_q <= i_req_data_i;
        end else if (i_res_ready_o) begin
            i_pend_q <= 1'b0;
        end
    end

    // Port D request buffer: capture when empty, release on its response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_pend_q <= 1'b0;
            d_rw_q   <= 1'b0;
            d_addr_q <= '0;
            d_data_q <= '0;
        end else if (d_cap) begin
            d_pend_q <= 1'b1;
            d_rw_q   <= d_req_rw_i;
            d_addr_q <= d_req_addr_i;
            d_data_q <= d_req_data_i;
        end else if (d_res_ready_o) begin
            d_pend_q <= 1'b0;
        end
    end

    // Performance counters, free-running with wrap
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_i_q    <= '0;
            gnt_d_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (i_res_ready_o) gnt_i_q <= gnt_i_q + CNT_W'(1);
            if (d_res_ready_o) gnt_d_q <= gnt_d_q + CNT_W'(1);
            if (conflict)      conflict_q <= conflict_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: two instances (round-robin and fixed D priority)
// share one input stream; each is compared every cycle against its own
// transaction-level model, plus directed scenarios with literal expectations.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         i_vld, i_rw, d_vld, d_rw;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] i_wd, d_wd;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    logic         mem_valid [2];
    logic         mem_rw    [2];
    logic [31:0]  mem_addr  [2];
    logic [127:0] mem_wdata [2];
    logic         i_rdy     [2];
    logic         d_rdy     [2];
    logic [127:0] i_rd      [2];
    logic [127:0] d_rd      [2];
    logic [31:0]  gnt_i     [2];
    logic [31:0]  gnt_d     [2];
    logic [31:0]  conf      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .FIXED_PRIO(g)) dut (
            .clk_i(clk), .rst_ni(rst_n),
            .i_req_valid_i(i_vld), .i_req_rw_i(i_rw), .i_req_addr_i(i_addr), .i_req_data_i(i_wd),
            .i_res_ready_o(i_rdy[g]), .i_res_data_o(i_rd[g]),
            .d_req_valid_i(d_vld), .d_req_rw_i(d_rw), .d_req_addr_i(d_addr), .d_req_data_i(d_wd),
            .d_res_ready_o(d_rdy[g]), .d_res_data_o(d_rd[g]),
            .mem_valid_o(mem_valid[g]), .mem_rw_o(mem_rw[g]), .mem_addr_o(mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
            .gnt_i_cnt_o(gnt_i[g]), .gnt_d_cnt_o(gnt_d[g]), .conflict_cnt_o(conf[g])
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Model per instance m, per port p (0 = I, 1 = D): buffered requests,
    // the transaction currently on the memory port, and the counters.
    bit           m_pend [2][2];
    bit           m_rw   [2][2];
    logic [31:0]  m_addr [2][2];
    logic [127:0] m_data [2][2];
    bit           m_busy [2];
    int           m_own  [2];
    int           m_last [2];
    logic [31:0]  m_gnt  [2][2];
    logic [31:0]  m_conf [2];

    task automatic chk(input string name, input int m, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h", name, m, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                m_pend[m][p] = 0; m_rw[m][p] = 0; m_addr[m][p] = '0; m_data[m][p] = '0;
                m_gnt[m][p] = '0;
            end
            m_busy[m] = 0; m_own[m] = 0; m_last[m] = 1; m_conf[m] = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_update();
        bit           vld [2];
        bit           rw  [2];
        logic [31:0]  ad  [2];
        logic [127:0] wd  [2];
        bit           cap [2];
        vld[0] = i_vld; rw[0] = i_rw; ad[0] = i_addr; wd[0] = i_wd;
        vld[1] = d_vld; rw[1] = d_rw; ad[1] = d_addr; wd[1] = d_wd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++)
                cap[p] = vld[p] && !m_pend[m][p] && !(m_busy[m] && mem_ready && m_own[m] == p);
            if (m_busy[m]) begin
                if (mem_ready) begin
                    m_pend[m][m_own[m]] = 0;
                    m_gnt[m][m_own[m]]  = m_gnt[m][m_own[m]] + 32'd1;
                    m_last[m] = m_own[m];
                    m_busy[m] = 0;
                end
            end else if (m_pend[m][0] || m_pend[m][1]) begin
                if (m_pend[m][0] && m_pend[m][1]) begin
                    m_conf[m] = m_conf[m] + 32'd1;
                    m_own[m]  = (m == 1) ? 1 : 1 - m_last[m];
                end else begin
                    m_own[m]  = m_pend[m][0] ? 0 : 1;
                end
                m_busy[m] = 1;
            end
            for (int p = 0; p < 2; p++)
                if (cap[p]) begin
                    m_pend[m][p] = 1; m_rw[m][p] = rw[p]; m_addr[m][p] = ad[p]; m_data[m][p] = wd[p];
                end
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            int o;
            o = m_own[m];
            chk("mem_valid", m, mem_valid[m], m_busy[m]);
            chk("mem_rw",    m, mem_rw[m],    m_busy[m] ? m_rw[m][o] : 1'b0);
            chk("mem_addr",  m, mem_addr[m],  m_busy[m] ? m_addr[m][o] : 32'h0);
            chk("mem_wdata", m, mem_wdata[m], m_busy[m] ? m_data[m][o] : 128'h0);
            chk("i_ready",   m, i_rdy[m],     m_busy[m] && mem_ready && o == 0);
            chk("d_ready",   m, d_rdy[m],     m_busy[m] && mem_ready && o == 1);
            chk("i_data",    m, i_rd[m],      mem_rdata);
            chk("d_data",    m, d_rd[m],      mem_rdata);
            chk("gnt_i",     m, gnt_i[m],     m_gnt[m][0]);
            chk("gnt_d",     m, gnt_d[m],     m_gnt[m][1]);
            chk("conflict",  m, conf[m],      m_conf[m]);
        end
    endtask

    // Inputs are set just after the falling edge; check, then take the rising edge
    task automatic eval();
        #1;
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle_inputs();
        i_vld = 0; i_rw = 0; i_addr = '0; i_wd = '0;
        d_vld = 0; d_rw = 0; d_addr = '0; d_wd = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    localparam logic [127:0] PAT_A5 = {4{32'hA5A5A5A5}};
    localparam logic [127:0] PAT_DW = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        model_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset state: every output zero
        eval();
        for (int m = 0; m < 2; m++) begin
            chk("rst_mem_valid", m, mem_valid[m], 1'b0);
            chk("rst_mem_addr",  m, mem_addr[m],  32'h0);
            chk("rst_counters",  m, {gnt_i[m], gnt_d[m], conf[m]}, 96'h0);
        end
        adv();

        // Single I fill with 2-cycle request latency and same-cycle response
        i_vld = 1; i_rw = 0; i_addr = 32'h100;
        step();
        idle_inputs();
        eval(); chk("t1_c1_mem_valid", 0, mem_valid[0], 1'b0); adv();
        eval(); chk("t1_c2_mem_valid", 0, mem_valid[0], 1'b1);
        chk("t1_c2_mem_addr", 0, mem_addr[0], 32'h100); adv();
        step(); step();
        mem_ready = 1; mem_rdata = PAT_A5;
        eval(); chk("t1_i_ready", 0, i_rdy[0], 1'b1); chk("t1_i_data", 0, i_rd[0], PAT_A5);
        chk("t1_d_ready", 0, d_rdy[0], 1'b0); adv();
        idle_inputs();
        eval(); chk("t1_gnt_i", 0, gnt_i[0], 32'd1); chk("t1_model_gnt_i", 0, m_gnt[0][0], 32'd1); adv();

        // Ties: round-robin serves I then D twice; fixed priority serves D first
        do_reset();
        i_vld = 1; i_addr = 32'h200; d_vld = 1; d_rw = 1; d_addr = 32'h300; d_wd = PAT_DW;
        step();
        idle_inputs();
        step();
        eval(); chk("t2_first_rr", 0, mem_addr[0], 32'h200); chk("t3_first_fix", 1, mem_addr[1], 32'h300); adv();
        mem_ready = 1;
        eval(); chk("t2_rr_i_ready", 0, i_rdy[0], 1'b1); chk("t3_fix_d_ready", 1, d_rdy[1], 1'b1); adv();
        mem_ready = 0;
        step();
        mem_ready = 1;
        eval(); chk("t2_second_rr", 0, mem_addr[0], 32'h300); chk("t3_second_fix", 1, mem_addr[1], 32'h200); adv();
        mem_ready = 0;
        i_vld = 1; i_addr = 32'h200; d_vld = 1; d_rw = 1; d_addr = 32'h300; d_wd = PAT_DW;
        step();
        idle_inputs();
        step();
        mem_ready = 1;
        eval(); chk("t2_repeat_rr", 0, mem_addr[0], 32'h200); chk("t2_conflict", 0, conf[0], 32'd2);
        chk("t2_model_conflict", 0, m_conf[0], 32'd2); chk("t3_repeat_fix", 1, mem_addr[1], 32'h300); adv();
        mem_ready = 0;
        step();
        mem_ready = 1;
        step();
        mem_ready = 0;
        eval(); chk("t2_gnt", 0, {gnt_i[0], gnt_d[0]}, {32'd2, 32'd2}); chk("t3_gnt", 1, {gnt_i[1], gnt_d[1]}, {32'd2, 32'd2}); adv();

        // One-cycle D write-back pulse while I owns the port
        i_vld = 1; i_addr = 32'h400;
        step();
        idle_inputs();
        step();
        d_vld = 1; d_rw = 1; d_addr = 32'h2A0; d_wd = PAT_DW;
        step();
        idle_inputs();
        mem_ready = 1;
        step();
        mem_ready = 0;
        step();
        mem_ready = 1;
        eval();
        for (int m = 0; m < 2; m++) begin
            chk("t4_mem_rw", m, mem_rw[m], 1'b1);
            chk("t4_mem_addr", m, mem_addr[m], 32'h2A0);
            chk("t4_mem_wdata", m, mem_wdata[m], PAT_DW);
        end
        adv();
        mem_ready = 0;
        step();

        // I valid held through its own ready cycle gives one transaction only
        i_vld = 1; i_addr = 32'h500;
        step(); step(); step();
        mem_ready = 1;
        step();
        idle_inputs();
        eval(); chk("t5_c4_mem_valid", 0, mem_valid[0], 1'b0); adv();
        eval(); chk("t5_c5_mem_valid", 0, mem_valid[0], 1'b0);
        chk("t5_gnt", 0, {gnt_i[0], gnt_d[0]}, {32'd4, 32'd3}); adv();

        // Reset while busy, then a stray memory ready in IDLE
        i_vld = 1; i_addr = 32'h600; d_vld = 1; d_addr = 32'h700;
        step();
        idle_inputs();
        step(); step();
        rst_n = 0;
        step();
        rst_n = 1;
        mem_ready = 1; mem_rdata = PAT_A5;
        eval();
        for (int m = 0; m < 2; m++) begin
            chk("t6_mem_valid", m, mem_valid[m], 1'b0);
            chk("t6_stray_ready", m, {i_rdy[m], d_rdy[m]}, 2'b00);
            chk("t6_counters", m, {gnt_i[m], gnt_d[m], conf[m]}, 96'h0);
        end
        adv();
        idle_inputs();
        eval(); chk("t6_slots_empty", 0, mem_valid[0], 1'b0); adv();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            i_vld     = ($urandom_range(0, 9) < 3);
            i_rw      = 1'($urandom_range(0, 1));
            i_addr    = $urandom;
            i_wd      = {$urandom, $urandom, $urandom, $urandom};
            d_vld     = ($urandom_range(0, 9) < 3);
            d_rw      = 1'($urandom_range(0, 1));
            d_addr    = $urandom;
            d_wd      = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = ($urandom_range(0, 9) < 3);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
